// File: rtl/xor_dut_arbiter.sv
// Round-robin arbiter that shares one untagged, delayed XOR datapath among
// N requesters. One transaction is in flight at a time. A watchdog turns a
// stalled transaction into an error response.
//
// Handshake rule for every valid/ready pair in this block:
// A transfer happens on a rising CLK edge where both valid (or en) and ready
// (or rdy) are high. The valid side keeps its payload stable until that edge.
// The ready side may assert or deassert at any time. req_rdy is the
// exception: it is a combinational function of req_valid and may only be high
// for the requester currently winning arbitration.
module xor_dut_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [N-1:0]         req_valid,
  input  logic [N-1:0]         req_a,
  input  logic [N-1:0]         req_b,
  output logic [N-1:0]         req_rdy,
  output logic [N-1:0]         resp_valid,
  output logic                 resp_data,
  output logic                 resp_err,
  input  logic [N-1:0]         resp_rdy,
  output logic                 dut_a_data,
  output logic                 dut_a_en,
  input  logic                 dut_a_rdy,
  output logic                 dut_b_data,
  output logic                 dut_b_en,
  input  logic                 dut_b_rdy,
  input  logic                 dut_y_data,
  input  logic                 dut_y_en,
  output logic                 dut_y_rdy,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id,
  output logic [CNT_W-1:0]     txn_count,
  output logic                 err_sticky,
  output logic [1:0]           state_dbg
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT_Y = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic            op_a;
  logic            op_b;
  logic            a_sent;
  logic            b_sent;
  logic [TW-1:0]   timer;

  logic            win_found;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   scan_idx;
  logic            a_done;
  logic            b_done;
  logic            expire;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = IW'((int'(rr_ptr) + k) % N);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Output decode from the registered state; operand data is held in op_a/op_b.
  always_comb begin
    req_rdy    = (state == S_IDLE && win_found) ? (N'(1) << win_id) : '0;
    resp_valid = (state == S_RESP) ? (N'(1) << grant_id) : '0;
    dut_a_en   = (state == S_ISSUE) && !a_sent;
    dut_b_en   = (state == S_ISSUE) && !b_sent;
    dut_y_rdy  = (state == S_WAIT_Y);
    dut_a_data = op_a;
    dut_b_data = op_b;
    busy       = (state != S_IDLE);
    state_dbg  = state;
    a_done     = a_sent || (dut_a_en && dut_a_rdy);
    b_done     = b_sent || (dut_b_en && dut_b_rdy);
    expire     = (timer == TW'(TIMEOUT - 1));
  end

  // Transaction sequencer: grant, issue operands, await result, respond.
  // A y completion on the expiry edge takes priority over the abort.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      op_a       <= 1'b0;
      op_b       <= 1'b0;
      a_sent     <= 1'b0;
      b_sent     <= 1'b0;
      timer      <= '0;
      resp_data  <= 1'b0;
      resp_err   <= 1'b0;
      txn_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            op_a     <= req_a[win_id];
            op_b     <= req_b[win_id];
            grant_id <= win_id;
            a_sent   <= 1'b0;
            b_sent   <= 1'b0;
            timer    <= '0;
            resp_err <= 1'b0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (expire) begin
            resp_err   <= 1'b1;
            resp_data  <= 1'b0;
            err_sticky <= 1'b1;
            state      <= S_RESP;
          end else begin
            timer  <= timer + 1'b1;
            a_sent <= a_done;
            b_sent <= b_done;
            if (a_done && b_done) begin
              state <= S_WAIT_Y;
            end
          end
        end
        S_WAIT_Y: begin
          if (dut_y_en) begin
            resp_data <= dut_y_data;
            resp_err  <= 1'b0;
            state     <= S_RESP;
          end else if (expire) begin
            resp_err   <= 1'b1;
            resp_data  <= 1'b0;
            err_sticky <= 1'b1;
            state      <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_rdy[grant_id]) begin
            rr_ptr <= (grant_id == IW'(N - 1)) ? '0 : grant_id + 1'b1;
            if (!resp_err) begin
              txn_count <= txn_count + 1'b1;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_dut_arbiter.sv
// Bench for xor_dut_arbiter: directed scenarios followed by a random phase,
// with a reference model built from the arbitration and response rules and a
// behavioural XOR datapath that computes y one cycle after it holds both operands.
module tb_xor_dut_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic [N-1:0]         req_valid, req_a, req_b, req_rdy, resp_valid, resp_rdy;
  logic                 resp_data, resp_err;
  logic                 dut_a_data, dut_a_en, dut_a_rdy;
  logic                 dut_b_data, dut_b_en, dut_b_rdy;
  logic                 dut_y_data, dut_y_en, dut_y_rdy;
  logic                 busy, err_sticky;
  logic [$clog2(N)-1:0] grant_id;
  logic [CNT_W-1:0]     txn_count;
  logic [1:0]           state_dbg;

  xor_dut_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .resp_rdy(resp_rdy),
    .dut_a_data(dut_a_data), .dut_a_en(dut_a_en), .dut_a_rdy(dut_a_rdy),
    .dut_b_data(dut_b_data), .dut_b_en(dut_b_en), .dut_b_rdy(dut_b_rdy),
    .dut_y_data(dut_y_data), .dut_y_en(dut_y_en), .dut_y_rdy(dut_y_rdy),
    .busy(busy), .grant_id(grant_id), .txn_count(txn_count),
    .err_sticky(err_sticky), .state_dbg(state_dbg)
  );

  // ---------------- behavioural XOR datapath ----------------
  logic a_rdy_en, b_rdy_en, y_block;
  logic dp_got_a, dp_got_b, dp_y_pend, dp_y;

  assign dut_a_rdy  = !dp_got_a && a_rdy_en;
  assign dut_b_rdy  = !dp_got_b && b_rdy_en;
  assign dut_y_en   = dp_y_pend && !y_block;
  assign dut_y_data = dp_y;

  // Result is computed from the operand lines one cycle after both are held.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dp_got_a <= 1'b0; dp_got_b <= 1'b0; dp_y_pend <= 1'b0; dp_y <= 1'b0;
    end else begin
      if (dut_a_en && dut_a_rdy) dp_got_a <= 1'b1;
      if (dut_b_en && dut_b_rdy) dp_got_b <= 1'b1;
      if (dp_got_a && dp_got_b && !dp_y_pend) begin
        dp_y_pend <= 1'b1;
        dp_y      <= dut_a_data ^ dut_b_data;
        dp_got_a  <= 1'b0;
        dp_got_b  <= 1'b0;
      end
      if (dut_y_en && dut_y_rdy) dp_y_pend <= 1'b0;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int         checks = 0;
  int         errors = 0;
  logic [0:0] exp_q[$];
  int         gid_q[$];
  int         grant_log[$];
  int         data_log[$];
  int         responses = 0;
  int         m_ptr, m_count, m_last_gid;
  logic       m_sticky, m_expect_err;
  int         n0, k, lowa, lowb;
  int         exp_g[5];
  int         exp_d[5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_clear();
    exp_q.delete(); gid_q.delete();
    m_ptr = 0; m_count = 0; m_last_gid = 0; m_sticky = 1'b0; m_expect_err = 1'b0;
  endtask

  // One clock: check outputs against the model, predict acceptance and
  // response, then advance to the next falling edge.
  task automatic cycle();
    logic was_busy;
    int   g, w;
    #1;
    was_busy = (gid_q.size() != 0);
    chk("txn_count", txn_count, m_count & 32'hFFFF);
    chk("busy", busy, was_busy);
    chk("grant_id", grant_id, m_last_gid);
    if (was_busy) begin
      g = gid_q[0];
      if (resp_valid != '0) begin
        chk("resp_valid_onehot", resp_valid, onehot(g));
        if (m_expect_err) m_sticky = 1'b1;
        if (resp_rdy[g]) begin
          if (m_expect_err) begin
            chk("resp_err_abort", resp_err, 1);
            chk("resp_data_abort", resp_data, 0);
          end else begin
            chk("resp_err", resp_err, 0);
            chk("resp_data", resp_data, exp_q[0]);
            m_count++;
          end
          data_log.push_back(int'(resp_data));
          void'(exp_q.pop_front());
          void'(gid_q.pop_front());
          m_ptr = (g + 1) % N;
          responses++;
        end
      end
      chk("req_rdy_busy", req_rdy, 0);
    end else begin
      chk("resp_valid_idle", resp_valid, 0);
      w = -1;
      for (int i = 0; i < N; i++) begin
        if (w < 0 && req_valid[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      end
      chk("req_rdy", req_rdy, (w < 0) ? '0 : onehot(w));
      if (w >= 0) begin
        exp_q.push_back(req_a[w] ^ req_b[w]);
        gid_q.push_back(w);
        grant_log.push_back(w);
        m_last_gid = w;
      end
    end
    chk("err_sticky", err_sticky, m_sticky);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic run_until_idle(input int limit);
    int c;
    c = 0;
    while (gid_q.size() != 0 && c < limit) begin
      cycle();
      c++;
    end
    chk("drain_bound", gid_q.size(), 0);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_req_rdy"}, req_rdy, 0);
    chk({pfx, "_resp_valid"}, resp_valid, 0);
    chk({pfx, "_resp_data"}, resp_data, 0);
    chk({pfx, "_resp_err"}, resp_err, 0);
    chk({pfx, "_a_en"}, dut_a_en, 0);
    chk({pfx, "_b_en"}, dut_b_en, 0);
    chk({pfx, "_a_data"}, dut_a_data, 0);
    chk({pfx, "_b_data"}, dut_b_data, 0);
    chk({pfx, "_y_rdy"}, dut_y_rdy, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_grant_id"}, grant_id, 0);
    chk({pfx, "_txn_count"}, txn_count, 0);
    chk({pfx, "_err_sticky"}, err_sticky, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // ---------------- directed steps, then random ----------------
  initial begin
    RST_N = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_rdy = '0;
    a_rdy_en = 1'b1; b_rdy_en = 1'b1; y_block = 1'b0;
    model_clear();
    repeat (2) @(negedge CLK);
    #1 chk_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // All four requesters continuously valid, a=i[0], b=i[1].
    resp_rdy = '1; req_a = 4'b1010; req_b = 4'b1100; req_valid = 4'b1111;
    grant_log.delete(); data_log.delete();
    n0 = responses; k = 0;
    while (responses - n0 < 5 && k < 100) begin cycle(); k++; end
    req_valid = '0;
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{0, 1, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_g[i]);
      chk("rr_data_seq", (i < data_log.size()) ? data_log[i] : -1, exp_d[i]);
    end

    // Single requester 1, a=1 b=0, latency E0..E3.
    req_valid = 4'b0010; req_a = 4'b0010; req_b = 4'b0000;
    cycle();
    req_valid = '0;
    chk("t1_a_en_e0", dut_a_en, 1);
    chk("t1_b_en_e0", dut_b_en, 1);
    chk("t1_a_data", dut_a_data, 1);
    chk("t1_b_data", dut_b_data, 0);
    cycle();
    chk("t1_a_en_e1", dut_a_en, 0);
    chk("t1_y_rdy_e1", dut_y_rdy, 1);
    cycle();
    chk("t1_no_resp_e2", resp_valid, 0);
    cycle();
    chk("t1_resp_valid_e3", resp_valid, 4'b0010);
    chk("t1_resp_data_e3", resp_data, 1);
    chk("t1_resp_err_e3", resp_err, 0);
    cycle();
    chk("t1_txn_count", txn_count, 6);
    chk("t1_idle", busy, 0);

    // b channel stalled 5 cycles; result arrives exactly on the expiry edge.
    req_valid = 4'b0100; req_a = 4'b0100; req_b = 4'b0100; b_rdy_en = 1'b0;
    cycle();
    req_valid = '0;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk("t3_a_en", dut_a_en, 0);
      chk("t3_b_en_stall", dut_b_en, 1);
      chk("t3_a_hold", dut_a_data, 1);
      chk("t3_b_hold", dut_b_data, 1);
    end
    b_rdy_en = 1'b1;
    cycle();
    chk("t3_b_en_e6", dut_b_en, 0);
    chk("t3_y_rdy_e6", dut_y_rdy, 1);
    cycle();
    chk("t3_a_hold_e7", dut_a_data, 1);
    chk("t3_b_hold_e7", dut_b_data, 1);
    cycle();
    chk("t3_resp_valid_e8", resp_valid, 4'b0100);
    chk("t3_resp_data", resp_data, 0);
    chk("t3_resp_err", resp_err, 0);
    run_until_idle(10);

    // Response withheld on requester 2 while requester 0 waits.
    resp_rdy = 4'b1011;
    req_valid = 4'b0100; req_a = 4'b0000; req_b = 4'b0100;
    cycle();
    req_valid = 4'b0001; req_a = 4'b0000; req_b = 4'b0000;
    repeat (3) cycle();
    for (int i = 0; i < 10; i++) begin
      chk("t5_resp_held", resp_valid, 4'b0100);
      chk("t5_req_rdy_zero", req_rdy, 0);
      cycle();
    end
    resp_rdy = '1;
    cycle();
    cycle();
    req_valid = '0;
    chk("t5_grant_after", grant_log[$], 0);
    run_until_idle(10);

    // Datapath never returns y: watchdog abort 8 cycles after issue entry.
    y_block = 1'b1; m_expect_err = 1'b1;
    req_valid = 4'b1000; req_a = 4'b1000; req_b = 4'b0000;
    cycle();
    req_valid = '0;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      chk("t4_no_resp", resp_valid, 0);
    end
    cycle();
    chk("t4_resp_valid_e8", resp_valid, 4'b1000);
    chk("t4_resp_err", resp_err, 1);
    chk("t4_resp_data", resp_data, 0);
    chk("t4_err_sticky", err_sticky, 1);
    chk("t4_y_rdy_dropped", dut_y_rdy, 0);
    cycle();
    chk("t4_txn_unchanged", txn_count, 9);
    m_expect_err = 1'b0;

    // Reset pulse while waiting for y.
    req_valid = 4'b0010; req_a = 4'b0010; req_b = 4'b0010;
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    chk("t6_in_wait", dut_y_rdy, 1);
    RST_N = 1'b0;
    #1 chk_zero("t6_reset");
    model_clear();
    y_block = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    req_valid = 4'b1111; req_a = 4'b0101; req_b = 4'b0000;
    cycle();
    req_valid = '0;
    chk("t6_grant_rr0", grant_log[$], 0);
    run_until_idle(20);
    chk("t6_txn_count", txn_count, 1);

    // Random traffic with bounded datapath stalls.
    n0 = responses; lowa = 0; lowb = 0;
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom_range(0, 15));
      req_a     = N'($urandom_range(0, 15));
      req_b     = N'($urandom_range(0, 15));
      resp_rdy  = N'($urandom_range(0, 15));
      a_rdy_en  = (lowa >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      b_rdy_en  = (lowb >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      lowa      = a_rdy_en ? 0 : lowa + 1;
      lowb      = b_rdy_en ? 0 : lowb + 1;
      cycle();
    end
    req_valid = '0; resp_rdy = '1; a_rdy_en = 1'b1; b_rdy_en = 1'b1;
    run_until_idle(50);
    chk("rand_progress", (responses - n0) >= 20, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xor_dut_arbiter.md
Name: xor_dut_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one delayed XOR datapath (1-bit a/b inputs with en/rdy, 1-bit y output with en/rdy) among N requesters.
- Accepts one (a,b) operand pair from the winning requester and drives both operand channels into the datapath.
- Collects y and returns it to the same requester on a per-requester response handshake.
- Exactly one transaction is outstanding at a time, because the datapath carries no tag. A watchdog aborts transactions that stall.

Parameters:
- N, 4, number of requesters (2..16).
- TIMEOUT, 64, cycles allowed in ISSUE+WAIT_Y before abort (>=8).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- req_valid  in  N  request valid, one bit per requester
- req_a  in  N  operand a, bit i belongs to requester i
- req_b  in  N  operand b, bit i belongs to requester i
- req_rdy  out  N  request accepted, at most one bit high
- resp_valid  out  N  response valid, at most one bit high
- resp_data  out  1  XOR result, shared by all requesters
- resp_err  out  1  response is a timeout abort
- resp_rdy  in  N  response consumed
- dut_a_data  out  1  operand a to datapath
- dut_a_en  out  1  operand a enable
- dut_a_rdy  in  1  datapath ready for a
- dut_b_data  out  1  operand b to datapath
- dut_b_en  out  1  operand b enable
- dut_b_rdy  in  1  datapath ready for b
- dut_y_data  in  1  datapath result
- dut_y_en  in  1  result valid
- dut_y_rdy  out  1  result accept
- busy  out  1  state != IDLE
- grant_id  out  clog2(N)  index of the current or last granted requester
- txn_count  out  CNT_W  completed non-error transactions, wraps at 2^CNT_W
- err_sticky  out  1  set on any timeout, cleared only by reset

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, grant_id=0, all registered outputs 0, txn_count=0, err_sticky=0, a_sent=b_sent=0, timer=0.
- State machine: IDLE -> ISSUE -> WAIT_Y -> RESP -> IDLE.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_rdy[winner]=1, combinational from req_valid and rr_ptr; all other req_rdy bits 0.
  - req_rdy is 0 in every other state.
  - On acceptance edge: latch req_a[winner] and req_b[winner] into op_a/op_b, set grant_id=winner, go to ISSUE.
- ISSUE:
  - dut_a_en = !a_sent and dut_b_en = !b_sent; the two channels are independent.
  - a_sent sets on an edge where dut_a_en & dut_a_rdy; b_sent likewise.
  - The two operands may be accepted in different cycles.
  - Go to WAIT_Y on the edge where the second operand is accepted.
- dut_a_data/dut_b_data hold op_a/op_b from ISSUE through WAIT_Y, since the datapath samples data at compute time, not at capture.
- WAIT_Y:
  - dut_y_rdy=1; it is 0 in every other state.
  - On dut_y_en edge: capture resp_data=dut_y_data, resp_err=0, go to RESP.
- RESP:
  - resp_valid[grant_id]=1.
  - On resp_rdy[grant_id] edge: go to IDLE, set rr_ptr=(grant_id+1) mod N, increment txn_count (when !resp_err).
  - resp_rdy on non-granted bits is ignored.
- Watchdog:
  - timer increments each cycle in ISSUE/WAIT_Y and clears on entry to ISSUE.
  - When timer==TIMEOUT-1 and no completion occurs that edge, go to RESP with resp_err=1, resp_data=0, and set err_sticky.
  - All dut_*_en outputs and dut_y_rdy drop the same edge.
  - Completion on the same edge as expiry wins (normal response).
- Latency with an idle datapath: acceptance edge E0; operands accepted E1; datapath y_en rises E2; result captured E3; resp_valid high from E3. Earliest next acceptance is one cycle after the response handshake.
- A request held with req_valid while not granted is never dropped. Deasserting req_valid before grant withdraws it with no side effect.
- Reset mid-transaction aborts with no response. The datapath shares RST_N and clears with it.

Test Plan:
- Single requester 1, a=1 b=0, resp_rdy tied 1 -> req_rdy[1] at E0, resp_valid[1] with resp_data=1 at E3, txn_count=1, resp_err=0.
- All four requesters valid continuously with a=i[0], b=i[1] -> grants in order 0,1,2,3,0. resp_data sequence 0,1,1,0,0. No requester starved.
- dut_b_rdy held 0 for 5 cycles after ISSUE entry, a=1 b=1 -> a accepted E1, b accepted E6, dut_a_data/dut_b_data stable until capture, resp_data=0.
- dut_y_en forced 0 and TIMEOUT=8 -> resp_valid with resp_err=1 and resp_data=0 exactly 8 cycles after ISSUE entry. err_sticky=1, txn_count unchanged.
- resp_rdy[2] withheld for 10 cycles while requester 0 is valid -> resp_valid[2] held, req_rdy all 0. Requester 0 is granted only after the handshake.
- RST_N pulsed low during WAIT_Y -> all outputs 0 immediately. After release, a new request completes normally with rr_ptr=0.
